spi_flash_responder: RTL and testbench

SPI flash responder that sits on the far end of the SPI bus driven by the APB SPI master / XIP bridge and plays the role of the boot flash. It decodes the standard read command (0x03 + 24-bit address), fetches a 32-bit word through a simple request/acknowledge memory port, and shifts it back on MISO MSB-first. Used in simulation SoC top-levels and as a flash stand-in for FPGA bring-up.

---
 rtl/spi_flash_responder_if.sv | 23 ++
 rtl/spi_flash_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// rtl/spi_flash_responder_if.sv - SPI pins and word-fetch memory port of the flash responder
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              spi_sck;
  logic              spi_ss;
  logic              spi_mosi;
  logic              spi_miso;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  spi_sck, spi_ss, spi_mosi, mem_rdata, mem_ack,
    output spi_miso, mem_req, mem_addr
  );

  modport master (
    output spi_sck, spi_ss, spi_mosi, mem_rdata, mem_ack,
    input  spi_miso, mem_req, mem_addr
  );
endinterface

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 boot-flash stand-in serving 0x03 reads from a word memory port
// SPI_FLASH_RESPONDER_FAST_READ_EN adds 0x0B fast read with 8 dummy clocks.
module spi_flash_responder #(
  parameter int ADDR_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  spi_flash_responder_if.slave  bus,
  output logic                  cmd_err,
  output logic                  data_err
);

  localparam int         CNT_W    = 6;
  localparam logic [7:0] CMD_READ = 8'h03;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  localparam logic [7:0] CMD_FAST = 8'h0B;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_FETCH,
    S_DATA,
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    S_DUMMY,
`endif
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-2:0]      sh_in_q, sh_in_d;
  logic [31:0]            data_sr_q, data_sr_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic                   mem_req_q, mem_req_d;
  logic                   miso_q, miso_d;
  logic                   cmd_err_q, cmd_err_d;
  logic                   data_err_q, data_err_d;
  logic                   pend_q, pend_d;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  logic                   fast_q, fast_d;
`endif

  logic              sck_s, ss_s, mosi_s, rise, fall;
  logic [ADDR_W-1:0] sh_next;

  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign ss_s    = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_prev_q;
  assign fall    = ~sck_s & sck_prev_q;
  assign sh_next = {sh_in_q, mosi_s};

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
    sck_prev_d  = sck_s;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_in_d    = sh_in_q;
    data_sr_d  = data_sr_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = 1'b0;
    miso_d     = miso_q;
    cmd_err_d  = 1'b0;
    data_err_d = 1'b0;
    pend_d     = pend_q;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    fast_d     = fast_q;
`endif
    // Deselect wins over everything and abandons any outstanding fetch.
    if (ss_s) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = '0;
          miso_d  = 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
          fast_d  = 1'b0;
`endif
        end
        S_CMD: if (rise) begin
          sh_in_d = sh_next[ADDR_W-2:0];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (sh_next[7:0] == CMD_READ) begin
              state_d = S_ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            end else if (sh_next[7:0] == CMD_FAST) begin
              state_d = S_ADDR;
              fast_d  = 1'b1;
`endif
            end else begin
              cmd_err_d = 1'b1;
              state_d   = S_IGNORE;
            end
          end
        end
        S_ADDR: if (rise) begin
          sh_in_d = sh_next[ADDR_W-2:0];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W-1)) begin
            cnt_d      = '0;
            mem_addr_d = {sh_next[ADDR_W-1:2], 2'b00};
            mem_req_d  = 1'b1;
            pend_d     = 1'b1;
            state_d    = S_FETCH;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            if (fast_q) state_d = S_DUMMY;
`endif
          end
        end
        // A fall before the ack means the master is already clocking out bit 31.
        S_FETCH: begin
          if (fall) begin
            miso_d     = 1'b0;
            data_sr_d  = '0;
            data_err_d = 1'b1;
            pend_d     = 1'b0;
            state_d    = S_DATA;
          end else if (bus.mem_ack && pend_q) begin
            data_sr_d = bus.mem_rdata;
            pend_d    = 1'b0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (fall) begin
            miso_d    = data_sr_q[31];
            data_sr_d = {data_sr_q[30:0], 1'b0};
          end
          if (rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(31)) begin
              cnt_d      = '0;
              mem_addr_d = mem_addr_q + ADDR_W'(4);
              mem_req_d  = 1'b1;
              pend_d     = 1'b1;
              state_d    = S_FETCH;
            end
          end
        end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        S_DUMMY: begin
          miso_d = 1'b0;
          if (bus.mem_ack && pend_q) begin
            data_sr_d = bus.mem_rdata;
            pend_d    = 1'b0;
          end
          if (rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d   = '0;
              state_d = pend_d ? S_FETCH : S_DATA;
            end
          end
        end
`endif
        S_IGNORE: miso_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_in_q     <= '0;
      data_sr_q   <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      miso_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      data_err_q  <= 1'b0;
      pend_q      <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_in_q     <= sh_in_d;
      data_sr_q   <= data_sr_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      miso_q      <= miso_d;
      cmd_err_q   <= cmd_err_d;
      data_err_q  <= data_err_d;
      pend_q      <= pend_d;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      fast_q      <= fast_d;
`endif
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign cmd_err      = cmd_err_q;
  assign data_err     = data_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - scoreboard bench for spi_flash_responder driving SPI mode 0 and a word memory
module tb_spi_flash_responder;

  localparam int HALF = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_err, data_err;

  spi_flash_responder_if #(.ADDR_W(24)) bus();

  spi_flash_responder #(.ADDR_W(24), .SYNC_STAGES(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .cmd_err  (cmd_err),
    .data_err (data_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [23:0] exp_addr_q[$];
  int          req_cnt = 0;
  int          cmd_err_cnt = 0;
  int          data_err_cnt = 0;
  int          late_dly = 0;
  logic [23:0] req_a;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return (a == 24'h000010) ? 32'hDEADBEEF : {8'hA5, a};
  endfunction

  always @(negedge clock) begin
    if (cmd_err === 1'b1) cmd_err_cnt++;
    if (data_err === 1'b1) data_err_cnt++;
  end

  // Memory model: acks each request after late_dly cycles; late_dly is one-shot.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (bus.mem_req === 1'b1) begin
        req_a = bus.mem_addr;
        req_cnt++;
        check("req_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
        if (exp_addr_q.size() != 0) check("req_addr", {8'h0, req_a}, {8'h0, exp_addr_q.pop_front()});
        repeat (late_dly) @(negedge clock);
        late_dly      = 0;
        bus.mem_rdata = mem_word(req_a);
        bus.mem_ack   = 1'b1;
        @(negedge clock);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
      end
    end
  end

  task automatic spi_bit(input logic b, output logic r);
    bus.spi_mosi = b;
    repeat (HALF) @(negedge clock);
    r = bus.spi_miso;
    bus.spi_sck = 1'b1;
    repeat (HALF) @(negedge clock);
    bus.spi_sck = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic r;
    for (int i = n - 1; i >= 0; i--) spi_bit(v[i], r);
  endtask

  task automatic spi_begin();
    @(negedge clock);
    bus.spi_ss = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clock);
    bus.spi_ss = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  task automatic read_txn(input logic [7:0] cmd, input logic [23:0] addr, input int nwords, input int ndummy);
    int          req0;
    logic [31:0] w;
    logic        r;
    spi_begin();
    req0 = req_cnt;
    send_bits({24'h0, cmd}, 8);
    send_bits({8'h0, addr}, 24);
    for (int d = 0; d < ndummy; d++) spi_bit(1'b0, r);
    for (int k = 0; k < nwords; k++) begin
      w = '0;
      for (int i = 0; i < 32; i++) begin
        if (k == 0 && i == 31) check("req_once", req_cnt - req0, 32'd1);
        spi_bit(1'b0, r);
        w = {w[30:0], r};
      end
      check("miso_word", w, exp_q.pop_front());
    end
    spi_end();
    check("addr_q_drained", exp_addr_q.size(), 32'd0);
  endtask

  task automatic bad_cmd_txn(input logic [7:0] cmd);
    int          req0, ce0;
    logic [31:0] acc;
    logic        r;
    req0 = req_cnt;
    ce0  = cmd_err_cnt;
    acc  = '0;
    spi_begin();
    send_bits({24'h0, cmd}, 8);
    for (int i = 0; i < 32; i++) begin
      spi_bit(1'b1, r);
      acc = {acc[30:0], r};
    end
    spi_end();
    check("ignore_miso", acc, 32'h0);
    check("cmd_err_pulse", cmd_err_cnt - ce0, 32'd1);
    check("ignore_no_req", req_cnt - req0, 32'd0);
  endtask

  initial begin
    int          req0, de0;
    logic        r;
    bus.spi_ss   = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_miso", {31'd0, bus.spi_miso}, 32'd0);
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_addr", {8'h0, bus.mem_addr}, 32'd0);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    check("rst_data_err", {31'd0, data_err}, 32'd0);

    exp_q.push_back(32'hDEADBEEF);
    exp_addr_q.push_back(24'h000010);
    exp_addr_q.push_back(24'h000014);
    read_txn(8'h03, 24'h000010, 1, 0);
    check("no_data_err", data_err_cnt, 32'd0);

    bad_cmd_txn(8'h9F);

    exp_q.push_back(32'hDEADBEEF);
    exp_addr_q.push_back(24'h000010);
    exp_addr_q.push_back(24'h000014);
    read_txn(8'h03, 24'h000013, 1, 0);

    exp_q.push_back(mem_word(24'hFFFFFC));
    exp_q.push_back(mem_word(24'h000000));
    exp_addr_q.push_back(24'hFFFFFC);
    exp_addr_q.push_back(24'h000000);
    exp_addr_q.push_back(24'h000004);
    read_txn(8'h03, 24'hFFFFFC, 2, 0);

    de0 = data_err_cnt;
    late_dly = 20;
    exp_q.push_back(32'h0);
    exp_addr_q.push_back(24'h000200);
    exp_addr_q.push_back(24'h000204);
    read_txn(8'h03, 24'h000200, 1, 0);
    check("data_err_pulse", data_err_cnt - de0, 32'd1);

    req0 = req_cnt;
    spi_begin();
    send_bits(32'h03, 8);
    send_bits(32'h123, 12);
    spi_end();
    check("abort_no_req", req_cnt - req0, 32'd0);

    exp_q.push_back(mem_word(24'h000080));
    exp_addr_q.push_back(24'h000080);
    exp_addr_q.push_back(24'h000084);
    read_txn(8'h03, 24'h000080, 1, 0);

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    exp_q.push_back(mem_word(24'h000100));
    exp_addr_q.push_back(24'h000100);
    exp_addr_q.push_back(24'h000104);
    read_txn(8'h0B, 24'h000100, 1, 8);
`else
    bad_cmd_txn(8'h0B);
`endif

    exp_addr_q.push_back(24'h000040);
    spi_begin();
    send_bits(32'h03, 8);
    send_bits(32'h000040, 24);
    for (int i = 0; i < 10; i++) spi_bit(1'b0, r);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {bus.spi_miso, bus.mem_req, cmd_err, data_err, 4'h0, bus.mem_addr}, 32'h0);
    bus.spi_ss = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    exp_q.push_back(32'hDEADBEEF);
    exp_addr_q.push_back(24'h000010);
    exp_addr_q.push_back(24'h000014);
    read_txn(8'h03, 24'h000010, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
